// File: rtl/fastata_pio.sv
// fastata_pio: Gayle-window IDE/ATA PIO cycle generator with programmable T1/T2/T4/Teoc.
// Define FASTATA_IORDY_EN to add IORDY wait-state extension with timeout.
module fastata_pio #(
    parameter logic [16:0] IDE_BASE = 17'h001B4,
    parameter int          CW       = 6,
    parameter int          T1_RST   = 2,
    parameter int          T2_RST   = 5,
    parameter int          T4_RST   = 1,
    parameter int          TEOC_RST = 1,
    parameter int          TMO      = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          TS,
    input  logic          RW,
    input  logic [31:0]   A,
    input  logic          IDEWAIT,
    input  logic          CFG_WE,
    input  logic [1:0]    CFG_SEL,
    input  logic [CW-1:0] CFG_DATA,
    output logic [1:0]    IDECS,
    output logic          IOR,
    output logic          IOW,
    output logic          TA,
    output logic          ACCESS,
    output logic          BUSY,
    output logic          TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, IOWAIT, HOLD, RECOVER
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [CW-1:0] t1, t2, t4, teoc;
    logic          cur_rw, cur_a12, n_rw, n_a12;
    logic          pend, pend_rw, pend_a12;
    logic          n_pend, n_pend_rw, n_pend_a12;
    logic          start, act, strb;
    logic [1:0]    cs_q, cs_n;
    logic          ior_q, iow_q, ta_q;
    logic          ior_n, iow_n, ta_n;
    logic          unused_bits;

    // Down-counter reload: a field of 0 behaves like 1.
    function automatic logic [CW-1:0] ld(input logic [CW-1:0] f);
        return (f == '0) ? '0 : f - CW'(1);
    endfunction

    assign ACCESS = (A[31:15] != IDE_BASE);
    assign start  = !TS && !ACCESS;
    assign BUSY   = (state != IDLE) || pend;
    assign IDECS  = cs_q;
    assign IOR    = ior_q;
    assign IOW    = iow_q;
    assign TA     = ta_q;

`ifdef FASTATA_IORDY_EN
    localparam int WW = $clog2(TMO + 1);
    logic [WW-1:0] wcnt, n_wcnt;
    logic          tset, tmo_q;
    assign TIMEOUT     = tmo_q;
    assign unused_bits = ^{A[14:13], A[11:0]};
`else
    assign TIMEOUT     = 1'b0;
    assign unused_bits = ^{IDEWAIT, A[14:13], A[11:0]};
`endif

    always_comb begin
        nstate     = state;
        ncnt       = cnt;
        n_rw       = cur_rw;
        n_a12      = cur_a12;
        n_pend     = pend;
        n_pend_rw  = pend_rw;
        n_pend_a12 = pend_a12;
`ifdef FASTATA_IORDY_EN
        n_wcnt     = wcnt;
        tset       = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (pend) begin
                    nstate = SETUP;
                    ncnt   = ld(t1);
                    n_rw   = pend_rw;
                    n_a12  = pend_a12;
                    n_pend = 1'b0;
                end else if (start) begin
                    nstate = SETUP;
                    ncnt   = ld(t1);
                    n_rw   = RW;
                    n_a12  = A[12];
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    nstate = STROBE;
                    ncnt   = ld(t2);
                end else begin
                    ncnt = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
`ifdef FASTATA_IORDY_EN
                    if (!IDEWAIT) begin
                        nstate = IOWAIT;
                        n_wcnt = WW'(TMO - 1);
                    end else begin
                        nstate = HOLD;
                        ncnt   = ld(t4);
                    end
`else
                    nstate = HOLD;
                    ncnt   = ld(t4);
`endif
                end else begin
                    ncnt = cnt - CW'(1);
                end
            end
            IOWAIT: begin
`ifdef FASTATA_IORDY_EN
                if (IDEWAIT) begin
                    nstate = HOLD;
                    ncnt   = ld(t4);
                end else if (wcnt == '0) begin
                    nstate = HOLD;
                    ncnt   = ld(t4);
                    tset   = 1'b1;
                end else begin
                    n_wcnt = wcnt - WW'(1);
                end
`else
                nstate = IDLE;
`endif
            end
            HOLD: begin
                if (cnt == '0) begin
                    nstate = RECOVER;
                    ncnt   = ld(teoc);
                end else begin
                    ncnt = cnt - CW'(1);
                end
            end
            RECOVER: begin
                if (cnt == '0) nstate = IDLE;
                else           ncnt   = cnt - CW'(1);
            end
            default: nstate = IDLE;
        endcase
        // Only one start can queue behind the running cycle.
        if (state != IDLE && start && !pend) begin
            n_pend     = 1'b1;
            n_pend_rw  = RW;
            n_pend_a12 = A[12];
        end
    end

    always_comb begin
        act   = (nstate == SETUP) || (nstate == STROBE) ||
                (nstate == IOWAIT) || (nstate == HOLD);
        strb  = (nstate == STROBE) || (nstate == IOWAIT);
        cs_n  = act ? (n_a12 ? 2'b01 : 2'b10) : 2'b11;
        ior_n = !(strb && n_rw);
        iow_n = !(strb && !n_rw);
        ta_n  = !(nstate == HOLD && state != HOLD);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_rw   <= 1'b1;
            cur_a12  <= 1'b0;
            pend     <= 1'b0;
            pend_rw  <= 1'b1;
            pend_a12 <= 1'b0;
            cs_q     <= 2'b11;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            ta_q     <= 1'b1;
        end else begin
            state    <= nstate;
            cnt      <= ncnt;
            cur_rw   <= n_rw;
            cur_a12  <= n_a12;
            pend     <= n_pend;
            pend_rw  <= n_pend_rw;
            pend_a12 <= n_pend_a12;
            cs_q     <= cs_n;
            ior_q    <= ior_n;
            iow_q    <= iow_n;
            ta_q     <= ta_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            t1   <= CW'(T1_RST);
            t2   <= CW'(T2_RST);
            t4   <= CW'(T4_RST);
            teoc <= CW'(TEOC_RST);
        end else if (CFG_WE) begin
            unique case (CFG_SEL)
                2'd0:    t1   <= CFG_DATA;
                2'd1:    t2   <= CFG_DATA;
                2'd2:    t4   <= CFG_DATA;
                default: teoc <= CFG_DATA;
            endcase
        end
    end

`ifdef FASTATA_IORDY_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wcnt  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wcnt <= n_wcnt;
            if (tset)        tmo_q <= 1'b1;
            else if (CFG_WE) tmo_q <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/fastata_pio.md
Name: fastata_pio

Overview:
- Second-generation Amiga IDE/ATA PIO cycle generator for the accelerator CPLD/FPGA.
- Decodes the Gayle-compatible IDE window and drives the chip-selects and IOR/IOW strobes.
- Returns the CPU transfer-acknowledge (TA).
- Adds over the first generation:
  - runtime-programmable T1/T2/T4/Teoc timings, so any PIO mode 0-4 works at any CPU clock;
  - an explicit state machine with a queued back-to-back start;
  - IORDY wait-state extension with timeout.

Parameters:
- IDE_BASE, 17'h001B4, value A[31:15] must equal for an IDE hit (0x00DA0000 window).
- CW, 6, width of the timing counters and timing fields.
- T1_RST, 2, reset value of the setup field (address/CS valid to strobe), in clocks.
- T2_RST, 5, reset value of the strobe-width field, in clocks.
- T4_RST, 1, reset value of the hold field (strobe high, CS held), in clocks.
- TEOC_RST, 1, reset value of the recovery field (CS high before the next start), in clocks.
- TMO, 255, IORDY timeout in clocks (used only with FASTATA_IORDY_EN).

Ports:
- CLK, input, 1, system clock.
- RESET, input, 1, asynchronous active-low reset.
- TS, input, 1, active-low CPU transfer start; one-cycle pulse.
- RW, input, 1, 1 = read, 0 = write.
- A, input, 32, CPU address.
- IDEWAIT, input, 1, drive IORDY; low = extend strobe.
- CFG_WE, input, 1, active-high timing-register write strobe.
- CFG_SEL, input, 2, field select: 0=T1, 1=T2, 2=T4, 3=TEOC.
- CFG_DATA, input, CW, timing value in clocks.
- IDECS, output, 2, active-low {CS1,CS0}.
- IOR, output, 1, active-low read strobe.
- IOW, output, 1, active-low write strobe.
- TA, output, 1, active-low transfer acknowledge.
- ACCESS, output, 1, combinational active-low IDE address hit: (A[31:15] != IDE_BASE).
- BUSY, output, 1, high when state != IDLE or a start is pending.
- TIMEOUT, output, 1, sticky high after an IORDY timeout; cleared by any CFG_WE.

Behaviour:
- Reset, asynchronous low:
  - IDECS=2'b11, IOR=IOW=TA=1, BUSY=0, TIMEOUT=0;
  - state IDLE, pending cleared;
  - timing fields reload their *_RST values.
- Start condition: TS==0 && ACCESS==0 at a rising edge.
- Start latching:
  - In IDLE: latch RW and A[12], go to SETUP.
  - In any other state: set pending and latch RW/A[12] into pending regs. RECOVER→IDLE then immediately takes the pending start (SETUP next cycle).
  - A second start while pending is already set is ignored.
- Field programming:
  - Fields are read at entry to each state; a CFG_WE mid-cycle affects only later states.
  - A field value of 0 is treated as 1.
- Outputs are registered. Relative to the start edge E:
  - SETUP (T1 clocks, from E+1): the selected CS is low. A[12]=1 → IDECS=2'b01; A[12]=0 → 2'b10.
  - STROBE (T2 clocks): CS low; IOR low if RW=1, IOW low if RW=0.
  - WAIT (optional feature only): entered if IDEWAIT=0 on the last STROBE clock. Strobe stays low until IDEWAIT=1, or until TMO clocks elapse (then set TIMEOUT and exit).
  - HOLD (T4 clocks): strobes high, CS low; TA low for exactly the first HOLD clock.
  - RECOVER (TEOC clocks): CS high, strobes high. Then IDLE.
- Default latency, read: IOR low E+3..E+7, TA low at E+8, CS low E+1..E+8, IDLE at E+10.
- Strobes never overlap. IOR and IOW are never both low.
- Counters are CW bits wide. The down-counter loads field-1 on state entry, and the state exits when the count is 0.
- Reset mid-cycle aborts immediately to the reset values. No TA is issued.

Optional Feature:
- FASTATA_IORDY_EN defined:
  - WAIT state, TMO counter and TIMEOUT are implemented as above.
  - IDEWAIT is sampled only on the last STROBE clock and during WAIT.
- Not defined:
  - IDEWAIT is ignored; the WAIT state does not exist.
  - TIMEOUT is tied 0.
  - Strobe width is exactly T2.

Test Plan:
- Reset defaults; TS=0, A=32'h00DA0000, RW=1 at E:
  - IDECS=2'b10 E+1..E+8;
  - IOR=0 E+3..E+7, IOW=1 throughout;
  - TA=0 only at E+8;
  - BUSY=0 at E+10.
- Write with A=32'h00DA1000, RW=0: IDECS=2'b01, IOW=0 for 5 clocks, IOR=1 throughout.
- CFG_WE with SEL=1, DATA=2, then a read: IOR low exactly 2 clocks, TA at E+5. Write DATA=0 to SEL=0: setup is 1 clock.
- Second TS at E+6 during the first cycle: pending set. Second SETUP starts the clock after RECOVER ends, with no gap-free strobe overlap. A third TS is ignored.
- A=32'h00BF0000 with TS=0: ACCESS=1, no CS or strobe, BUSY stays 0.
- With FASTATA_IORDY_EN:
  - IDEWAIT=0 for 4 clocks from E+7: IOR extends 4 clocks, TA delayed 4.
  - IDEWAIT held 0: TIMEOUT=1 after 255 clocks, TA still issued.
  - RESET pulled low mid-STROBE: all outputs return to 1 asynchronously.
